// File: rtl/picoblaze_interrupt_controller.sv
// Multi-source interrupt controller for the PacoBlaze3 interrupt/interrupt_ack pair.
// Sources are synchronised, edge-latched as pending, masked and served round-robin one at a time.
module picoblaze_interrupt_controller #(
  parameter int         NUM_SOURCES = 4,
  parameter logic [7:0] BASE_ADDR   = 8'h10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SOURCES-1:0] irq_src,
  output logic                   interrupt,
  input  logic                   interrupt_ack,
  input  logic [7:0]             port_id,
  input  logic                   write_strobe,
  input  logic [7:0]             out_port,
  output logic [7:0]             read_data
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ASSERT     = 2'd1,
    ST_IN_SERVICE = 2'd2
  } state_e;

  function automatic logic [7:0] zext8(input logic [NUM_SOURCES-1:0] v);
    logic [7:0] r;
    r = 8'h00;
    r[NUM_SOURCES-1:0] = v;
    return r;
  endfunction

  logic [NUM_SOURCES-1:0] sync1_q, sync2_q, prev_q, edge_s;
  logic [NUM_SOURCES-1:0] mask_q, mask_d, pend_q, pend_d, ovr_q, ovr_d;
  logic [NUM_SOURCES-1:0] req_s, sel_oh_s;
  logic [2:0]             sel_q, sel_d, rr_q, rr_d, vector_q, vector_d, win_s;
  logic                   found_s, sel_req_s;
  state_e                 state_q, state_d;
  logic                   irq_q, irq_d;
  logic [7:0]             rdata_q, rdata_d;
  logic                   in_range_s, wr_mask_s, wr_pend_s, wr_eoi_s;

  assign in_range_s = (port_id[7:2] == BASE_ADDR[7:2]);
  assign wr_mask_s  = write_strobe && in_range_s && (port_id[1:0] == 2'd0);
  assign wr_pend_s  = write_strobe && in_range_s && (port_id[1:0] == 2'd1);
  assign wr_eoi_s   = write_strobe && in_range_s && (port_id[1:0] == 2'd3);
  assign edge_s     = sync2_q & ~prev_q;
  assign req_s      = pend_q & mask_q;
  assign interrupt  = irq_q;
  assign read_data  = rdata_q;

  // Two-flop synchroniser plus a history flop for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Round-robin search starting just above the last serviced source
  always_comb begin
    win_s    = 3'd0;
    found_s  = 1'b0;
    sel_oh_s = '0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (!found_s && req_s[i] && (i == ((int'(rr_q) + k) % NUM_SOURCES))) begin
          found_s = 1'b1;
          win_s   = 3'(i);
        end else begin
          found_s = found_s;
        end
      end
    end
    for (int i = 0; i < NUM_SOURCES; i++) begin
      sel_oh_s[i] = (sel_q == 3'(i));
    end
    sel_req_s = |(req_s & sel_oh_s);
  end

  // FSM next state: ack beats a simultaneous loss of the selected request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (found_s) state_d = ST_ASSERT; else state_d = ST_IDLE;
      ST_ASSERT: begin
        if (interrupt_ack)   state_d = ST_IN_SERVICE;
        else if (!sel_req_s) state_d = ST_IDLE;
        else                 state_d = ST_ASSERT;
      end
      ST_IN_SERVICE: if (wr_eoi_s) state_d = ST_IDLE; else state_d = ST_IN_SERVICE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and register-file updates; new edges win over clears
  always_comb begin
    irq_d    = (state_d == ST_ASSERT);
    mask_d   = wr_mask_s ? out_port[NUM_SOURCES-1:0] : mask_q;
    pend_d   = wr_pend_s ? (pend_q & ~out_port[NUM_SOURCES-1:0]) : pend_q;
    ovr_d    = wr_eoi_s ? '0 : ovr_q;
    sel_d    = ((state_q == ST_IDLE) && found_s) ? win_s : sel_q;
    rr_d     = rr_q;
    vector_d = vector_q;
    if ((state_q == ST_ASSERT) && interrupt_ack) begin
      pend_d   = pend_d & ~sel_oh_s;
      rr_d     = sel_q;
      vector_d = sel_q;
    end else begin
      rr_d     = rr_q;
    end
    ovr_d  = ovr_d | (edge_s & pend_q);
    pend_d = pend_d | edge_s;
  end

  // Pipelined read mux
  always_comb begin
    rdata_d = 8'h00;
    if (in_range_s) begin
      case (port_id[1:0])
        2'd0:    rdata_d = zext8(mask_q);
        2'd1:    rdata_d = zext8(pend_q);
        2'd2:    rdata_d = {(state_q == ST_IN_SERVICE), 4'b0000, vector_q};
        2'd3:    rdata_d = zext8(ovr_q);
        default: rdata_d = 8'h00;
      endcase
    end else begin
      rdata_d = 8'h00;
    end
  end

  // State and register storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      mask_q   <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      sel_q    <= 3'd0;
      rr_q     <= 3'(NUM_SOURCES - 1);
      vector_q <= 3'd0;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      vector_q <= vector_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: doc/picoblaze_interrupt_controller.md
Name: picoblaze_interrupt_controller

Overview:
Multi-source interrupt controller that shares the single PacoBlaze3 `interrupt` / `interrupt_ack` pair between up to 8 peripheral requesters. Sources are synchronised and edge-detected, then latched as pending, masked, and arbitrated round-robin. The controller drives the processor interrupt line and tracks the in-service source until software writes end-of-interrupt (EOI). It sits beside the processor on the port_id / write_strobe / out_port bus and feeds its registered read data into the in_port mux.

Parameters:
NUM_SOURCES, 4, number of interrupt requesters (1..8); register bits at or above NUM_SOURCES read 0 and ignore writes.
BASE_ADDR, 8'h10, port address of register 0; registers occupy BASE_ADDR+0..+3 (BASE_ADDR must be a multiple of 4).

Ports:
clk  input  1  system clock, all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
irq_src  input  NUM_SOURCES  asynchronous interrupt requests; a rising edge requests service
interrupt  output  1  to processor `interrupt`, registered
interrupt_ack  input  1  from processor `interrupt_ack`, one-cycle pulse
port_id  input  8  processor port address
write_strobe  input  1  processor write qualifier
out_port  input  8  processor write data
read_data  output  8  registered read data for the in_port mux

Behaviour:
- Reset (reset_n=0, asynchronous): interrupt=0, read_data=0, MASK=0, PENDING=0, OVERRUN=0, VECTOR=0, state=IDLE, rr_last=NUM_SOURCES-1.
- Synchroniser: 2-flop synchroniser per source, then a third flop for edge detect; edge = sync & ~prev. Sources must hold each level for at least 2 clk periods.
- PENDING[i] set on edge[i].
  - If PENDING[i] is already 1 at that edge, OVERRUN[i] is set (sticky).
  - Set wins over a simultaneous write-1-to-clear.
- Register map (write when write_strobe=1 and port_id matches):
  - +0 MASK: R/W; 1 = enabled.
  - +1 PENDING: read; write 1 to clear each bit.
  - +2 STATUS: read; bit7 = in-service valid, bits2:0 = VECTOR; writes ignored.
  - +3 OVERRUN / EOI: read returns OVERRUN; any write clears all OVERRUN bits and signals EOI.
- read_data: registered every cycle from a decode of port_id (pipelined mux); 8'h00 when port_id is outside the register range. Reads have no side effects.
- Arbitration: req = PENDING & MASK. The winner is the first set bit searching upward from rr_last+1, wrapping modulo NUM_SOURCES.
- FSM:
  - IDLE: if req≠0, capture the winner into sel, go to ASSERT, set interrupt=1 on the same edge. interrupt_ack in IDLE is ignored.
  - ASSERT: interrupt held at 1.
    - On interrupt_ack: interrupt=0, VECTOR=sel, in-service valid=1, clear PENDING[sel], rr_last=sel, go to IN_SERVICE.
    - If req[sel] drops (masked or cleared by software) before ack: interrupt=0, return to IDLE. Another source may be chosen on the following cycle.
    - If ack and loss of req[sel] occur on the same cycle, ack wins.
  - IN_SERVICE: interrupt=0; new edges still latch into PENDING. A write to +3 (EOI) clears valid and returns to IDLE. The next ASSERT can begin on the cycle after EOI.
- Only one interrupt is outstanding at a time; no nesting.
- Reset asserted mid-service returns everything to reset values immediately, including interrupt=0.

Test Plan:
- Reset, MASK=8'h01, pulse irq_src[0] for 3 cycles -> interrupt rises on the 4th clk edge after irq_src rises; PENDING reads 8'h01.
- Ack pulse while in ASSERT -> interrupt=0 on the next edge; STATUS reads 8'h80; PENDING reads 8'h00. Write +3 -> STATUS reads 8'h00.
- MASK=8'h0F, edges on sources 1 and 3 together -> first service vector 1; after EOI the second service is vector 3. Then edges on 1 and 3 again -> vector 1 first (rotation from rr_last=3).
- Two edges on source 2 with no service in between -> OVERRUN reads 8'h04; any write to +3 clears it.
- Source 0 pending with MASK=0 -> interrupt stays 0. Then set MASK=1 and, during ASSERT, clear MASK -> interrupt drops, state returns to IDLE, PENDING[0] still 1.
- reset_n pulsed low during IN_SERVICE -> all registers 0 and interrupt=0 asynchronously. Read of port 8'h20 -> read_data 8'h00.
